// File: rtl/alu_pkg.sv
// Shared ALU command encodings and the divider state encoding.
//   FUNCT_ADD / FUNCT_SUB / FUNCT_NOP : ALU Funct codes
//   div_state_e                       : seq_divider FSM states
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b001001;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b001010;
    localparam logic [FUNCT_W-1:0] FUNCT_NOP = 6'b000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEG_A = 3'd1,
        ST_NEG_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX_Q = 3'd4,
        ST_FIX_R = 3'd5,
        ST_DONE  = 3'd6
    } div_state_e;

endpackage

// File: rtl/alu.sv
// Combinational add/subtract ALU shared by the PA1 datapath.
//   Src1, Src2 : operands
//   Funct      : ADD / SUB / NOP
//   Result     : sum or difference (0 for NOP)
//   Carry      : carry-out for ADD, borrow for SUB (0 for NOP)
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  Src1,
    input  logic [DATA_W-1:0]  Src2,
    input  logic [FUNCT_W-1:0] Funct,
    output logic [DATA_W-1:0]  Result,
    output logic               Carry
);

    logic [DATA_W:0] w_wide;

    // Carry is bit 32 of the widened operation; for SUB that is the borrow.
    always_comb begin
        w_wide = '0;
        case (Funct)
            FUNCT_ADD: w_wide = {1'b0, Src1} + {1'b0, Src2};
            FUNCT_SUB: w_wide = {1'b0, Src1} - {1'b0, Src2};
            default:   w_wide = '0;
        endcase
        Result = w_wide[DATA_W-1:0];
        Carry  = w_wide[DATA_W];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider (signed/unsigned) using an external ALU.
//   clk, rst (sync, active-high)
//   start, signed_op, dividend, divisor : request, sampled in IDLE
//   busy, done, quotient, remainder, div_by_zero : status/results
//   alu_src1, alu_src2, alu_funct : registered ALU command
//   alu_result, alu_carry         : ALU response, same cycle
module seq_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   alu_src1,
    output logic [WIDTH-1:0]   alu_src2,
    output logic [FUNCT_W-1:0] alu_funct,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;       // dividend magnitude, then quotient
    logic [WIDTH-1:0] r_r, w_r_nxt;       // partial remainder
    logic [WIDTH-1:0] r_b, w_b_nxt;       // divisor magnitude
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_signed, w_signed_nxt;
    logic             r_sign_a, w_sign_a_nxt;
    logic             r_sign_b, w_sign_b_nxt;

    logic [WIDTH-1:0]   w_quot_nxt, w_rem_nxt, w_src1_nxt, w_src2_nxt;
    logic [FUNCT_W-1:0] w_funct_nxt;
    logic               w_dbz_nxt, w_busy_nxt, w_done_nxt;
    logic [WIDTH-1:0]   w_shift;
    logic               w_take;

    // State and data registers, including all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_q         <= '0;
            r_r         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_signed    <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            alu_funct   <= FUNCT_NOP;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_r         <= w_r_nxt;
            r_b         <= w_b_nxt;
            r_cnt       <= w_cnt_nxt;
            r_signed    <= w_signed_nxt;
            r_sign_a    <= w_sign_a_nxt;
            r_sign_b    <= w_sign_b_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            quotient    <= w_quot_nxt;
            remainder   <= w_rem_nxt;
            div_by_zero <= w_dbz_nxt;
            alu_src1    <= w_src1_nxt;
            alu_src2    <= w_src2_nxt;
            alu_funct   <= w_funct_nxt;
        end
    end

    // Next-state, datapath update, and the ALU command for the next cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_r_nxt      = r_r;
        w_b_nxt      = r_b;
        w_cnt_nxt    = r_cnt;
        w_signed_nxt = r_signed;
        w_sign_a_nxt = r_sign_a;
        w_sign_b_nxt = r_sign_b;
        w_quot_nxt   = quotient;
        w_rem_nxt    = remainder;
        w_dbz_nxt    = div_by_zero;
        w_src1_nxt   = '0;
        w_src2_nxt   = '0;
        w_funct_nxt  = FUNCT_NOP;

        // R[31] shifted out means S >= 2^32 > |B|, so the subtract always fits.
        w_shift = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
        w_take  = r_r[WIDTH-1] | ~alu_carry;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_signed_nxt = signed_op;
                    w_sign_a_nxt = dividend[WIDTH-1];
                    w_sign_b_nxt = divisor[WIDTH-1];
                    w_q_nxt      = dividend;
                    w_r_nxt      = '0;
                    w_b_nxt      = divisor;
                    w_dbz_nxt    = 1'b0;
                    if (divisor == '0) begin
                        w_state_nxt = ST_DONE;
                        w_quot_nxt  = '1;
                        w_rem_nxt   = dividend;
                        w_dbz_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_NEG_A;
                    end
                end
            end
            ST_NEG_A: begin
                if (r_signed & r_sign_a) w_q_nxt = alu_result;
                w_state_nxt = ST_NEG_B;
            end
            ST_NEG_B: begin
                if (r_signed & r_sign_b) w_b_nxt = alu_result;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_ITER;
            end
            ST_ITER: begin
                if (w_take) begin
                    w_r_nxt = alu_result;
                    w_q_nxt = {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    w_r_nxt = w_shift;
                    w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) w_state_nxt = ST_FIX_Q;
            end
            ST_FIX_Q: begin
                if (r_signed & (r_sign_a ^ r_sign_b)) w_q_nxt = alu_result;
                w_state_nxt = ST_FIX_R;
            end
            ST_FIX_R: begin
                if (r_signed & r_sign_a) w_r_nxt = alu_result;
                w_quot_nxt  = r_q;
                w_rem_nxt   = w_r_nxt;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        // ALU operands are registered, so they are prepared from next values.
        case (w_state_nxt)
            ST_NEG_A: begin
                w_funct_nxt = FUNCT_SUB;
                w_src2_nxt  = w_q_nxt;
            end
            ST_NEG_B: begin
                w_funct_nxt = FUNCT_SUB;
                w_src2_nxt  = w_b_nxt;
            end
            ST_ITER: begin
                w_funct_nxt = FUNCT_SUB;
                w_src1_nxt  = {w_r_nxt[WIDTH-2:0], w_q_nxt[WIDTH-1]};
                w_src2_nxt  = w_b_nxt;
            end
            ST_FIX_Q: begin
                w_funct_nxt = FUNCT_SUB;
                w_src2_nxt  = w_q_nxt;
            end
            ST_FIX_R: begin
                w_funct_nxt = FUNCT_SUB;
                w_src2_nxt  = w_r_nxt;
            end
            default: w_funct_nxt = FUNCT_NOP;
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench: seq_divider driving the real ALU.
module tb_seq_divider;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [5:0]  alu_funct;
    logic        alu_carry;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    alu u_alu (
        .Src1(alu_src1), .Src2(alu_src2), .Funct(alu_funct),
        .Result(alu_result), .Carry(alu_carry)
    );

    typedef struct {
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE (cycle 0). Optionally pulses a stray start
    // with other operands in cycle inj_cyc. Returns the done cycle (-1 if none).
    task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, output int lat, output int busy_lo);
        lat     = -1;
        busy_lo = 0;
        signed_op = sop; dividend = a; divisor = b; start = 1'b1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            start = (k == inj_cyc);
            if (k == inj_cyc) begin
                signed_op = 1'b0; dividend = 32'd9; divisor = 32'd3;
            end
            if (k == 5) check("funct_sub_busy", 32'(alu_funct), 32'(FUNCT_SUB));
            if (!busy) busy_lo++;
            if (done) lat = k;
        end
        start = 1'b0;
    endtask

    // Full check of one operation plus the cycle after done.
    task automatic do_vec(input string name, input vec_t v, input int inj_cyc);
        int lat, blo;
        run_op(v.sop, v.a, v.b, inj_cyc, lat, blo);
        check({name, "_latency"}, 32'(lat), v.dbz ? 32'd1 : 32'd37);
        check({name, "_busy_gaps"}, 32'(blo), 32'd0);
        check({name, "_quot"}, quotient, v.q);
        check({name, "_rem"}, remainder, v.r);
        check({name, "_dbz"}, 32'(div_by_zero), 32'(v.dbz));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_nop_idle"}, 32'(alu_funct), 32'(FUNCT_NOP));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[2]  = '{1'b0, 32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0};
        vecs[3]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[4]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[6]  = '{1'b0, 32'd123,        32'd0,          32'hFFFFFFFF,   32'd123,        1'b1};
        vecs[7]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[9]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};

        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_src1", alu_src1, 32'd0);
        check("rst_src2", alu_src2, 32'd0);
        check("rst_funct", 32'(alu_funct), 32'(FUNCT_NOP));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_vec($sformatf("vec%0d", i), vecs[i], -1);
        end

        // Stray start mid-operation must not disturb the running divide.
        do_vec("ignored_start", vecs[0], 10);

        // Divide-by-zero then a normal divide clears the flag.
        do_vec("dbz_again", vecs[6], -1);
        do_vec("dbz_cleared", vecs[7], -1);

        // Reset in cycle 20 aborts the operation without a done pulse.
        begin
            int ndone;
            signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                start = 1'b0;
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_quot", quotient, 32'd0);
            check("abort_rem", remainder, 32'd0);
            check("abort_funct", 32'(alu_funct), 32'(FUNCT_NOP));
            ndone = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done || busy) ndone++;
            end
            check("abort_no_done", 32'(ndone), 32'd0);
            do_vec("after_abort", vecs[7], -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential 32-bit integer divider (signed or unsigned) that drives the team's combinational add/subtract ALU as its only arithmetic resource. It sits between the PA1 top level, which issues start/operands and collects quotient/remainder, and an external ALU instance. The block acts as the initiator of the ALU's `Funct` command interface: it supplies `Src1`/`Src2`/`Funct` each cycle and consumes `Result`/`Carry`.

## Interface
- `WIDTH`, 32: operand width. Only 32 is required to be supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `signed_op` in 1: 1 = two's-complement division, 0 = unsigned. Sampled with `start`.
- `dividend` in 32: sampled with `start`.
- `divisor` in 32: sampled with `start`.
- `busy` out 1: high from the cycle after accept through the DONE cycle.
- `done` out 1: one-cycle pulse when results are valid.
- `quotient` out 32: result. Held until the next accept.
- `remainder` out 32: result. Held until the next accept.
- `div_by_zero` out 1: set with `done` when divisor == 0. Held until the next accept.
- `alu_src1` out 32: drives ALU `Src1`.
- `alu_src2` out 32: drives ALU `Src2`.
- `alu_funct` out 6: drives ALU `Funct`.
- `alu_result` in 32: ALU `Result`, same-cycle combinational.
- `alu_carry` in 1: ALU `Carry`, same-cycle combinational.

## Operation
- ALU commands:
  - ADD = 6'b001001, SUB = 6'b001010, NOP = 6'b000000.
  - The ALU returns 0/0 for NOP.
  - This block issues only SUB and NOP.
- Reset: state IDLE; all outputs are 0, including `alu_funct` = NOP.
- States: IDLE → NEG_A → NEG_B → ITER (×32) → FIX_Q → FIX_R → DONE → IDLE.
- Divide-by-zero path: if `divisor == 0` at accept, go IDLE → DONE directly, with `quotient = 32'hFFFFFFFF`, `remainder = dividend` (raw), `div_by_zero = 1`.
- NEG_A:
  - ALU gets SUB with src1 = 0, src2 = A.
  - Commit A ← `alu_result` only if `signed_op & A[31]`.
- NEG_B: same as NEG_A, applied to B.
- ITER, each cycle (restoring algorithm on {R, Q}, with R initialised to 0 and Q to |A|):
  - Form `S = {R[30:0], Q[31]}`; `ovf = R[31]` is the shifted-out bit.
  - Issue SUB with src1 = S, src2 = |B|.
  - Accept if `ovf | ~alu_carry`:
    - R ← `alu_result` (mod 2^32 is exact here).
    - Q ← {Q[30:0], 1}.
  - Otherwise:
    - R ← S.
    - Q ← {Q[30:0], 0}.
  - A 6-bit counter counts 0..31 and exits ITER after the 32nd iteration.
- FIX_Q: SUB with src1 = 0, src2 = Q. Commit if `signed_op & (sign_a ^ sign_b)`.
- FIX_R: SUB with src1 = 0, src2 = R. Commit if `signed_op & sign_a`. The remainder takes the sign of the dividend.
- DONE: `done = 1`; `quotient`, `remainder`, `div_by_zero` registered.
- NOP is issued on `alu_funct` in IDLE and DONE.
- Signed overflow (−2^31 / −1): `quotient = 32'h80000000`, `remainder = 0`, no flag.
- `start` while busy is ignored and operands are not resampled.
- `start` in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle.

## Timing
- Accept in cycle 0 (IDLE with `start = 1`).
- Normal path:
  - NEG_A = cycle 1, NEG_B = cycle 2.
  - ITER = cycles 3–34.
  - FIX_Q = cycle 35, FIX_R = cycle 36.
  - DONE/`done` = cycle 37.
- Latency is fixed at 37 cycles, independent of `signed_op` and operand values.
- Divide-by-zero path: `done` in cycle 1.
- `busy` is high in cycles 1..37 and low in IDLE.
- ALU path: registered state/data → combinational ALU → register, single cycle. ALU inputs are driven from registers only, with no input-to-output combinational path.
- `rst` at any cycle mid-operation returns the block to IDLE on the next edge, zeroes all outputs, and emits no `done`.

## Structure
- Shared package `alu_pkg` holds:
  - the Funct constants ADD/SUB/NOP;
  - the state enum.
- No sub-module: the ALU is instantiated alongside this block by the parent and connected through the `alu_*` ports.
- The bench instantiates the real ALU plus `seq_divider`.

## Test plan
- Unsigned 100 / 7 → `quotient` = 14, `remainder` = 2, `done` in cycle 37, `busy` high cycles 1–37.
- Unsigned 32'hFFFFFFFF / 1 → `quotient` = 32'hFFFFFFFF, `remainder` = 0. Also 32'hFFFFFFFF / 32'h80000000 → `quotient` = 1, `remainder` = 32'h7FFFFFFF (exercises the `ovf` path).
- Signed −7 / 2 → `quotient` = 32'hFFFFFFFD, `remainder` = 32'hFFFFFFFF. Signed 7 / −2 → `quotient` = 32'hFFFFFFFD, `remainder` = 1. Signed −2^31 / −1 → `quotient` = 32'h80000000, `remainder` = 0.
- Divisor 0 with dividend 123 → `done` in cycle 1, `quotient` = 32'hFFFFFFFF, `remainder` = 123, `div_by_zero` = 1. The next normal divide clears `div_by_zero`.
- `start` pulsed in cycle 10 with different operands → ignored; the original result is delivered in cycle 37.
- `rst` asserted in cycle 20 → all outputs 0 next cycle, no `done`. A fresh 9 / 3 then returns `quotient` = 3, `remainder` = 0.
